rhd_acq_sequencer: RTL and testbench

Sequences the RHD SPI master through chip bring-up (register writes, ADC calibration) and then a periodic per-channel CONVERT sweep.
- Tags each returned 16-bit ADC word with its channel and emits it as a sample stream.
- Sits between the SPI master and the sample FIFO / packetiser, and is the only block that drives the master's start/command inputs.
- Accounts for the RHD 2-command pipeline latency.

---
 rtl/rhd_pkg.sv | 51 +++++
 rtl/rhd_frame_timer.sv | 36 +++
 rtl/rhd_acq_sequencer.sv | 215 +++++++++++++++++++++
 tb/tb_rhd_acq_sequencer.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rhd_pkg.sv
// rhd_pkg: RHD command encodings, the bring-up register table and the
// sequencer state type shared by the acquisition sequencer files.
package rhd_pkg;

  localparam logic [15:0] CAL_CMD   = 16'h5500;
  localparam logic [15:0] DUMMY_CMD = 16'hFF00;

  // Bring-up writes in issue order: {reg[5:0], data[7:0]}
  localparam int CFG_ROM_LEN = 18;
  localparam logic [13:0] CFG_ROM [CFG_ROM_LEN] = '{
    {6'd0,  8'hDE}, {6'd1,  8'h20}, {6'd2,  8'h28}, {6'd3,  8'h02},
    {6'd4,  8'h9C}, {6'd5,  8'h00}, {6'd6,  8'h00}, {6'd7,  8'h00},
    {6'd8,  8'h16}, {6'd9,  8'h80}, {6'd10, 8'h17}, {6'd11, 8'h80},
    {6'd12, 8'h2C}, {6'd13, 8'h06}, {6'd14, 8'hFF}, {6'd15, 8'hFF},
    {6'd16, 8'hFF}, {6'd17, 8'hFF}
  };

  // Each WAIT state directly follows its ISSUE state in the encoding
  typedef enum logic [3:0] {
    ST_IDLE        = 4'd0,
    ST_CFG_ISSUE   = 4'd1,
    ST_CFG_WAIT    = 4'd2,
    ST_CAL_ISSUE   = 4'd3,
    ST_CAL_WAIT    = 4'd4,
    ST_DUMMY_ISSUE = 4'd5,
    ST_DUMMY_WAIT  = 4'd6,
    ST_CONV_ISSUE  = 4'd7,
    ST_CONV_WAIT   = 4'd8,
    ST_ARMED       = 4'd9,
    ST_ERROR       = 4'd10
  } state_e;

  function automatic logic [15:0] enc_write(input logic [5:0] addr, input logic [7:0] data);
    return {2'b10, addr, data};
  endfunction

  function automatic logic [15:0] enc_convert(input logic [5:0] ch);
    return {2'b00, ch, 8'h00};
  endfunction

  function automatic logic [15:0] cfg_cmd(input logic [4:0] idx);
    logic [13:0] entry;
    if (idx < 5'(CFG_ROM_LEN)) begin
      entry = CFG_ROM[idx];
      return enc_write(entry[13:8], entry[7:0]);
    end else begin
      return DUMMY_CMD;
    end
  endfunction

endpackage

// File: rtl/rhd_frame_timer.sv
// rhd_frame_timer: free-running sample-period counter; tick marks each wrap to 0.
module rhd_frame_timer
  import rhd_pkg::*;
#(
  parameter int PERIOD = 3500
) (
  input  logic clk,
  input  logic rstn,
  input  logic run,
  input  logic restart,
  output logic tick
);

  localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

  logic [CW-1:0] cnt_r;

  // period counter and registered wrap tick
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_r <= '0;
      tick  <= 1'b0;
    end else if (restart || !run) begin
      cnt_r <= '0;
      tick  <= 1'b0;
    end else if (cnt_r == LAST) begin
      cnt_r <= '0;
      tick  <= 1'b1;
    end else begin
      cnt_r <= cnt_r + 1'b1;
      tick  <= 1'b0;
    end
  end

endmodule

// File: rtl/rhd_acq_sequencer.sv
// rhd_acq_sequencer: drives the RHD SPI master through register bring-up, ADC
// calibration and periodic CONVERT sweeps, tagging each ADC result with its channel.
module rhd_acq_sequencer
  import rhd_pkg::*;
#(
  parameter int NUM_CH        = 32,
  parameter int NUM_CFG       = 18,
  parameter int SAMPLE_PERIOD = 3500,
  parameter int TIMEOUT       = 1023,
  parameter int CAL_DUMMIES   = 9
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        enable,
  output logic        spi_start,
  output logic [15:0] spi_cmd,
  input  logic        spi_done,
  input  logic [15:0] spi_rx,
  output logic        sample_valid,
  output logic [15:0] sample_data,
  output logic [5:0]  sample_ch,
  output logic        frame_start,
  output logic        running,
  output logic        overrun,
  output logic        fault
);

  localparam int WDW = $clog2(TIMEOUT + 1);
  localparam logic [WDW-1:0] LAST_WD = WDW'(TIMEOUT - 1);
  localparam logic [6:0] LAST_CFG   = 7'(NUM_CFG - 1);
  localparam logic [6:0] LAST_DUMMY = 7'(CAL_DUMMIES - 1);
  localparam logic [6:0] LAST_K     = 7'(NUM_CH + 1);
  localparam logic [6:0] NCH        = 7'(NUM_CH);

  state_e         state_r, state_n, adv_state_s;
  logic [6:0]     idx_r, idx_n, adv_idx_s;
  logic [WDW-1:0] wdog_r, wdog_n;
  logic [15:0]    cmd_s, issue_cmd_s;
  logic           start_s, smp_s, timeout_s, restart_s, tick_s;
  logic           enable_q_r, en_rise_s, in_conv_s;

  assign en_rise_s = enable && !enable_q_r;
  assign in_conv_s = (state_r == ST_CONV_ISSUE) || (state_r == ST_CONV_WAIT);
  assign restart_s = (state_r == ST_DUMMY_WAIT) && (state_n == ST_ARMED);

  rhd_frame_timer #(.PERIOD(SAMPLE_PERIOD)) u_timer (
    .clk     (clk),
    .rstn    (rstn),
    .run     (running),
    .restart (restart_s),
    .tick    (tick_s)
  );

  // command word for the current ISSUE state
  always_comb begin
    issue_cmd_s = DUMMY_CMD;
    case (state_r)
      ST_CFG_ISSUE:  issue_cmd_s = cfg_cmd(idx_r[4:0]);
      ST_CAL_ISSUE:  issue_cmd_s = CAL_CMD;
      ST_CONV_ISSUE: issue_cmd_s = (idx_r < NCH) ? enc_convert(idx_r[5:0]) : DUMMY_CMD;
      default:       issue_cmd_s = DUMMY_CMD;
    endcase
  end

  // where a completed transaction leads when enable is still high
  always_comb begin
    adv_state_s = ST_IDLE;
    adv_idx_s   = idx_r + 7'd1;
    case (state_r)
      ST_CFG_WAIT: begin
        if (idx_r == LAST_CFG) begin
          adv_state_s = ST_CAL_ISSUE;
          adv_idx_s   = 7'd0;
        end else begin
          adv_state_s = ST_CFG_ISSUE;
        end
      end
      ST_CAL_WAIT: begin
        adv_state_s = ST_DUMMY_ISSUE;
        adv_idx_s   = 7'd0;
      end
      ST_DUMMY_WAIT: begin
        if (idx_r == LAST_DUMMY) begin
          adv_state_s = ST_ARMED;
          adv_idx_s   = 7'd0;
        end else begin
          adv_state_s = ST_DUMMY_ISSUE;
        end
      end
      ST_CONV_WAIT: begin
        if (idx_r == LAST_K) begin
          adv_state_s = ST_ARMED;
          adv_idx_s   = 7'd0;
        end else begin
          adv_state_s = ST_CONV_ISSUE;
        end
      end
      default: begin
        adv_state_s = ST_IDLE;
        adv_idx_s   = 7'd0;
      end
    endcase
  end

  // next-state, transaction issue and watchdog logic
  always_comb begin
    state_n   = state_r;
    idx_n     = idx_r;
    wdog_n    = wdog_r;
    start_s   = 1'b0;
    cmd_s     = spi_cmd;
    smp_s     = 1'b0;
    timeout_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (enable) begin
          state_n = ST_CFG_ISSUE;
          idx_n   = 7'd0;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_CFG_ISSUE, ST_CAL_ISSUE, ST_DUMMY_ISSUE, ST_CONV_ISSUE: begin
        if (enable) begin
          start_s = 1'b1;
          cmd_s   = issue_cmd_s;
          wdog_n  = '0;
          state_n = state_e'(state_r + 4'd1);
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_CFG_WAIT, ST_CAL_WAIT, ST_DUMMY_WAIT, ST_CONV_WAIT: begin
        if (spi_done) begin
          // k=0,1 return the previous sweep's tail and are dropped
          smp_s = (state_r == ST_CONV_WAIT) && (idx_r >= 7'd2);
          if (enable) begin
            state_n = adv_state_s;
            idx_n   = adv_idx_s;
          end else begin
            state_n = ST_IDLE;
          end
        end else if (wdog_r == LAST_WD) begin
          timeout_s = 1'b1;
          state_n   = ST_ERROR;
        end else begin
          wdog_n = wdog_r + 1'b1;
        end
      end
      ST_ARMED: begin
        if (!enable) begin
          state_n = ST_IDLE;
        end else if (tick_s) begin
          state_n = ST_CONV_ISSUE;
          idx_n   = 7'd0;
        end else begin
          state_n = ST_ARMED;
        end
      end
      ST_ERROR: begin
        if (!enable) begin
          state_n = ST_IDLE;
        end else begin
          state_n = ST_ERROR;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // state, counters and registered outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r      <= ST_IDLE;
      idx_r        <= 7'd0;
      wdog_r       <= '0;
      enable_q_r   <= 1'b0;
      spi_start    <= 1'b0;
      spi_cmd      <= 16'h0000;
      sample_valid <= 1'b0;
      sample_data  <= 16'h0000;
      sample_ch    <= 6'd0;
      frame_start  <= 1'b0;
      running      <= 1'b0;
      overrun      <= 1'b0;
      fault        <= 1'b0;
    end else begin
      state_r      <= state_n;
      idx_r        <= idx_n;
      wdog_r       <= wdog_n;
      enable_q_r   <= enable;
      spi_start    <= start_s;
      spi_cmd      <= cmd_s;
      sample_valid <= smp_s;
      frame_start  <= smp_s && (idx_r == 7'd2);
      if (smp_s) begin
        sample_data <= spi_rx;
        sample_ch   <= idx_r[5:0] - 6'd2;
      end
      running <= (state_n == ST_ARMED) || (state_n == ST_CONV_ISSUE) ||
                 (state_n == ST_CONV_WAIT);
      if (en_rise_s) begin
        overrun <= 1'b0;
      end else if (tick_s && in_conv_s) begin
        overrun <= 1'b1;
      end
      if (en_rise_s) begin
        fault <= 1'b0;
      end else if (timeout_s) begin
        fault <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rhd_acq_sequencer.sv
// tb_rhd_acq_sequencer: directed bench with an SPI slave model (2-command result
// pipeline) and a vector table for the hand-driven CONVERT sweeps.
module tb_rhd_acq_sequencer;

  logic        clk, rstn, enable;
  logic        spi_start, spi_done, sample_valid, frame_start, running, overrun, fault;
  logic [15:0] spi_cmd, spi_rx, sample_data;
  logic [5:0]  sample_ch;

  logic        slv_done, man_done;
  logic [15:0] slv_rx, man_rx;
  assign spi_done = slv_done | man_done;
  assign spi_rx   = man_done ? man_rx : slv_rx;

  rhd_acq_sequencer #(
    .NUM_CH(4), .NUM_CFG(18), .SAMPLE_PERIOD(500), .TIMEOUT(1023), .CAL_DUMMIES(9)
  ) dut (
    .clk(clk), .rstn(rstn), .enable(enable),
    .spi_start(spi_start), .spi_cmd(spi_cmd), .spi_done(spi_done), .spi_rx(spi_rx),
    .sample_valid(sample_valid), .sample_data(sample_data), .sample_ch(sample_ch),
    .frame_start(frame_start), .running(running), .overrun(overrun), .fault(fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] rx;
    logic [15:0] cmd;
    logic        vld;
    logic [5:0]  ch;
    logic [15:0] data;
    logic        fs;
  } vec_t;

  typedef struct {
    logic [5:0]  ch;
    logic [15:0] data;
    logic        fs;
  } smp_t;

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          start_cnt = 0;
  int          slave_lat = 200;
  bit          slave_on = 1'b0;
  bit          hang_en = 1'b0;
  logic [15:0] cmd_log [$];
  smp_t        smp_q [$];
  int          fs_times [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_start(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (spi_start) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  function automatic logic [15:0] resp(input logic [15:0] c);
    if (c[15:14] == 2'b00) return 16'h1000 + {10'd0, c[13:8]};
    else return 16'hDEAD;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // command and sample monitors
  initial forever begin
    @(negedge clk);
    if (spi_start) begin
      start_cnt++;
      cmd_log.push_back(spi_cmd);
    end
    if (sample_valid) smp_q.push_back('{sample_ch, sample_data, frame_start});
    if (frame_start) fs_times.push_back(cyc);
  end

  // SPI slave: answers each start after slave_lat cycles with the result of the command two back
  initial begin
    logic [15:0] h1, h2, c;
    h1 = 16'h0; h2 = 16'h0;
    slv_done = 1'b0; slv_rx = 16'h0;
    forever begin
      @(negedge clk);
      if (spi_start && slave_on) begin
        c = spi_cmd;
        if (!(hang_en && c == 16'h8228)) begin
          repeat (slave_lat - 1) @(negedge clk);
          slv_rx = resp(h2);
          slv_done = 1'b1;
          @(negedge clk);
          slv_done = 1'b0;
        end
        h2 = h1;
        h1 = c;
      end
    end
  end

  initial begin
    vec_t        vecs [12];
    logic [15:0] exp_boot [28];
    logic [15:0] cfg_words [18];
    bit          ok;
    int          n0, cnt;

    cfg_words = '{16'h80DE, 16'h8120, 16'h8228, 16'h8302, 16'h849C, 16'h8500,
                  16'h8600, 16'h8700, 16'h8816, 16'h8980, 16'h8A17, 16'h8B80,
                  16'h8C2C, 16'h8D06, 16'h8EFF, 16'h8FFF, 16'h90FF, 16'h91FF};
    for (int i = 0; i < 18; i++) exp_boot[i] = cfg_words[i];
    exp_boot[18] = 16'h5500;
    for (int i = 19; i < 28; i++) exp_boot[i] = 16'hFF00;

    vecs[0]  = '{16'hAAA0, 16'h0000, 1'b0, 6'd0, 16'h0000, 1'b0};
    vecs[1]  = '{16'hAAA1, 16'h0100, 1'b0, 6'd0, 16'h0000, 1'b0};
    vecs[2]  = '{16'h1000, 16'h0200, 1'b1, 6'd0, 16'h1000, 1'b1};
    vecs[3]  = '{16'h1001, 16'h0300, 1'b1, 6'd1, 16'h1001, 1'b0};
    vecs[4]  = '{16'h1002, 16'hFF00, 1'b1, 6'd2, 16'h1002, 1'b0};
    vecs[5]  = '{16'h1003, 16'hFF00, 1'b1, 6'd3, 16'h1003, 1'b0};
    vecs[6]  = '{16'h5555, 16'h0000, 1'b0, 6'd0, 16'h0000, 1'b0};
    vecs[7]  = '{16'hAAAA, 16'h0100, 1'b0, 6'd0, 16'h0000, 1'b0};
    vecs[8]  = '{16'hF000, 16'h0200, 1'b1, 6'd0, 16'hF000, 1'b1};
    vecs[9]  = '{16'hF001, 16'h0300, 1'b1, 6'd1, 16'hF001, 1'b0};
    vecs[10] = '{16'hF002, 16'hFF00, 1'b1, 6'd2, 16'hF002, 1'b0};
    vecs[11] = '{16'hF003, 16'hFF00, 1'b1, 6'd3, 16'hF003, 1'b0};

    rstn = 1'b0; enable = 1'b0; man_done = 1'b0; man_rx = 16'h0;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_start", spi_start, 1'b0);
    chk("rst_cmd", spi_cmd, 16'h0000);
    chk("rst_valid", sample_valid, 1'b0);
    chk("rst_running", running, 1'b0);
    chk("rst_flags", {overrun, fault}, 2'b00);
    rstn = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_no_start", start_cnt, 0);

    // bring-up sequence
    cmd_log.delete();
    slave_on = 1'b1; slave_lat = 200; enable = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (running) begin ok = 1'b1; break; end
    end
    slave_on = 1'b0;
    chk("boot_reach_armed", ok, 1'b1);
    chk("boot_cmd_count", cmd_log.size(), 28);
    for (int i = 0; i < 28 && i < cmd_log.size(); i++) chk("boot_cmd", cmd_log[i], exp_boot[i]);
    chk("boot_no_samples", smp_q.size(), 0);

    // two hand-driven sweeps
    for (int i = 0; i < 12; i++) begin
      wait_start(2000, ok);
      chk("vec_start", ok, 1'b1);
      chk("vec_cmd", spi_cmd, vecs[i].cmd);
      repeat (3) @(negedge clk);
      chk("vec_cmd_hold", spi_cmd, vecs[i].cmd);
      man_rx = vecs[i].rx;
      man_done = 1'b1;
      @(negedge clk);
      man_done = 1'b0;
      chk("vec_valid", sample_valid, vecs[i].vld);
      chk("vec_fs", frame_start, vecs[i].fs);
      if (vecs[i].vld) begin
        chk("vec_ch", sample_ch, vecs[i].ch);
        chk("vec_data", sample_data, vecs[i].data);
      end
    end
    chk("no_overrun", overrun, 1'b0);
    chk("running_sweep", running, 1'b1);

    // sweep longer than one period: overrun, every second tick dropped
    smp_q.delete(); fs_times.delete();
    slave_lat = 120; slave_on = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 8000; i++) begin
      @(negedge clk);
      if (smp_q.size() >= 12) begin ok = 1'b1; break; end
    end
    chk("ovr_samples", ok, 1'b1);
    chk("ovr_flag", overrun, 1'b1);
    for (int i = 0; i < 12 && i < smp_q.size(); i++) begin
      chk("ovr_ch", smp_q[i].ch, 6'(i % 4));
      chk("ovr_data", smp_q[i].data, 16'h1000 + 16'(i % 4));
      chk("ovr_fs", smp_q[i].fs, (i % 4) == 0);
    end
    if (fs_times.size() >= 3) begin
      chk("ovr_period1", fs_times[1] - fs_times[0], 1000);
      chk("ovr_period2", fs_times[2] - fs_times[1], 1000);
    end else begin
      chk("ovr_frames", fs_times.size(), 3);
    end

    // disable while waiting on k=3
    ok = 1'b0;
    for (int i = 0; i < 12; i++) begin
      wait_start(2000, ok);
      if (ok && spi_cmd == 16'h0300) break;
      ok = 1'b0;
    end
    chk("dis_found_k3", ok, 1'b1);
    enable = 1'b0;
    smp_q.delete();
    @(negedge clk);
    n0 = start_cnt;
    repeat (400) @(negedge clk);
    chk("dis_one_sample", smp_q.size(), 1);
    if (smp_q.size() > 0) begin
      chk("dis_ch", smp_q[0].ch, 6'd1);
      chk("dis_data", smp_q[0].data, 16'h1001);
    end
    chk("dis_running", running, 1'b0);
    chk("dis_no_start", start_cnt, n0);

    // timeout on the 3rd CFG write
    hang_en = 1'b1;
    enable = 1'b1;
    @(negedge clk);
    chk("en_clears_overrun", overrun, 1'b0);
    wait_start(500, ok);
    chk("re_cfg0", spi_cmd, 16'h80DE);
    wait_start(500, ok);
    wait_start(500, ok);
    chk("hang_cmd", spi_cmd, 16'h8228);
    cnt = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      cnt++;
      if (fault) break;
    end
    chk("fault_latency", cnt, 1023);
    chk("fault_running", running, 1'b0);
    n0 = start_cnt;
    repeat (300) @(negedge clk);
    chk("fault_no_start", start_cnt, n0);
    chk("fault_sticky", fault, 1'b1);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    hang_en = 1'b0;
    enable = 1'b1;
    @(negedge clk);
    chk("fault_cleared", fault, 1'b0);
    wait_start(500, ok);
    chk("restart_start", ok, 1'b1);
    chk("restart_cfg0", spi_cmd, 16'h80DE);

    // async reset mid-transaction, stray spi_done afterwards
    repeat (10) @(negedge clk);
    rstn = 1'b0;
    enable = 1'b0;
    smp_q.delete();
    @(negedge clk);
    chk("mid_rst_cmd", spi_cmd, 16'h0000);
    chk("mid_rst_data", sample_data, 16'h0000);
    chk("mid_rst_out", {spi_start, sample_valid, frame_start, running, overrun, fault}, 6'b0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    n0 = start_cnt;
    repeat (250) @(negedge clk);
    chk("stray_no_sample", smp_q.size(), 0);
    chk("stray_no_start", start_cnt, n0);
    chk("stray_outputs", {spi_cmd, sample_ch, running, fault}, 24'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
